// File: rtl/dft_probe_capture.sv
// Probe capture controller: enables one probe, waits a settle time, samples its tdi line and
// packs the samples into a response word. Optional macro DFT_PROBE_CAPTURE_MAJORITY_EN selects 3-cycle majority sampling.
module dft_probe_capture #(
  parameter int NPROBE = 8,
  parameter int IDXW   = 3,
  parameter int MAXS   = 16,
  parameter int SETTLE = 4
) (
  input  logic              CELCLK,
  input  logic              CELRSTN,
  input  logic              CELG,
  input  logic              CELSUB,
  input  logic              CELV,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IDXW-1:0]   cmd_idx,
  input  logic [4:0]        cmd_cnt,
  output logic [NPROBE-1:0] ten,
  input  logic [NPROBE-1:0] tdi,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [MAXS-1:0]   rsp_data,
  output logic              rsp_err
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, RESP} state_t;

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic [4:0]    cnt_q;
  logic [4:0]    n_q;
  logic [4:0]    cnt_eff;
  logic          idx_bad;
  logic          cur_bit;
  logic          sample_bit;
  logic          sample_done;
  logic          unused_pins;

  assign unused_pins = ^{CELG, CELSUB, CELV};

  always_comb begin
    cnt_eff = cmd_cnt;
    if (cmd_cnt == 5'd0)
      cnt_eff = 5'd1;
    else if (32'(cmd_cnt) > MAXS)
      cnt_eff = 5'(MAXS);
  end

  assign idx_bad = (32'(cmd_idx) >= NPROBE);

  // ten is held one-hot on the selected probe for the whole capture, so it doubles as the tdi mux select
  assign cur_bit = |(tdi & ten);

`ifdef DFT_PROBE_CAPTURE_MAJORITY_EN
  logic [1:0] phase;
  logic       vote0;
  logic       vote1;

  assign sample_done = (phase == 2'd2);
  assign sample_bit  = (vote0 & vote1) | (vote0 & cur_bit) | (vote1 & cur_bit);

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      phase <= 2'd0;
      vote0 <= 1'b0;
      vote1 <= 1'b0;
    end else if (state == SAMPLE) begin
      case (phase)
        2'd0:    begin vote0 <= cur_bit; phase <= 2'd1; end
        2'd1:    begin vote1 <= cur_bit; phase <= 2'd2; end
        default: phase <= 2'd0;
      endcase
    end else begin
      phase <= 2'd0;
    end
  end
`else
  assign sample_done = 1'b1;
  assign sample_bit  = cur_bit;
`endif

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      ten        <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      settle_cnt <= '0;
      cnt_q      <= '0;
      n_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            cnt_q     <= cnt_eff;
            n_q       <= '0;
            rsp_data  <= '0;
            if (idx_bad) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              rsp_err    <= 1'b0;
              ten        <= NPROBE'(1) << cmd_idx;
              settle_cnt <= CW'(SETTLE - 1);
              state      <= WAIT;
            end
          end
        end
        WAIT: begin
          if (settle_cnt == '0)
            state <= SAMPLE;
          else
            settle_cnt <= settle_cnt - 1'b1;
        end
        SAMPLE: begin
          if (sample_done) begin
            rsp_data <= rsp_data | (MAXS'(sample_bit) << n_q);
            n_q      <= n_q + 5'd1;
            if (n_q + 5'd1 == cnt_q) begin
              ten       <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              settle_cnt <= CW'(SETTLE - 1);
              state      <= WAIT;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
